piezo_arb: RTL and testbench

Tone-playback arbiter and note engine for the piezo sounder. It shares the single piezo driver between three note requesters, such as the alarm melody SM, key-click beeps and the error tone. It grants one requester at a time under fixed priority and times the granted note's duration in 1/100 s units. It also generates the differential square wave from the note period in clocks and returns a one-cycle `note_over` to the owner when the note finishes.

---
 rtl/piezo_arb.sv | 173 +++++++++++++++++
 tb/tb_piezo_arb.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/piezo_arb.sv
// Fixed-priority arbiter sharing one piezo driver between three note requesters.
// It times the granted note in 1/100 s ticks and drives a differential square wave.
module piezo_arb #(
  parameter int CS_CLKS = 500000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  req,
  input  logic [14:0] note_per0,
  input  logic [14:0] note_per1,
  input  logic [14:0] note_per2,
  input  logic [7:0]  note_dur0,
  input  logic [7:0]  note_dur1,
  input  logic [7:0]  note_dur2,
  input  logic        stop,
  output logic [2:0]  gnt,
  output logic [2:0]  note_over,
  output logic        busy,
  output logic        piezo,
  output logic        piezo_n
);

  localparam int CS_W = (CS_CLKS > 1) ? $clog2(CS_CLKS) : 1;
  localparam logic [CS_W-1:0] CS_LAST = CS_W'(CS_CLKS - 1);

  typedef enum logic [0:0] {IDLE = 1'b0, PLAY = 1'b1} state_t;

  state_t           state_r, state_s;
  logic [2:0]       sel_r, sel_s;
  logic [14:0]      per_r, per_sel_s;
  logic [7:0]       dur_r, dur_sel_s;
  logic [14:0]      per_cnt_r;
  logic [CS_W-1:0]  cs_cnt_r;
  logic [7:0]       dur_cnt_r;
  logic [2:0]       note_over_r;
  logic             tick_s, done_s, tone_hi_s;

  // Lowest set request index wins; its note parameters are selected for latching
  always_comb begin
    sel_s     = 3'b000;
    per_sel_s = 15'd0;
    dur_sel_s = 8'd0;
    if (req[0]) begin
      sel_s     = 3'b001;
      per_sel_s = note_per0;
      dur_sel_s = note_dur0;
    end else if (req[1]) begin
      sel_s     = 3'b010;
      per_sel_s = note_per1;
      dur_sel_s = note_dur1;
    end else if (req[2]) begin
      sel_s     = 3'b100;
      per_sel_s = note_per2;
      dur_sel_s = note_dur2;
    end else begin
      sel_s     = 3'b000;
      per_sel_s = 15'd0;
      dur_sel_s = 8'd0;
    end
  end

  // Note ends on the tick that completes the last 1/100 s, or at once for dur=0
  always_comb begin
    tick_s = (cs_cnt_r == CS_LAST);
    if (dur_r == 8'd0) begin
      done_s = 1'b1;
    end else begin
      done_s = tick_s && (dur_cnt_r == (dur_r - 8'd1));
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; stop overrides both grant and completion
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (stop) begin
          state_s = IDLE;
        end else if (req != 3'b000) begin
          state_s = PLAY;
        end else begin
          state_s = IDLE;
        end
      end
      PLAY: begin
        if (stop || done_s) begin
          state_s = IDLE;
        end else begin
          state_s = PLAY;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // Latch the granted note and run the period, tick and duration counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_r       <= 3'b000;
      per_r       <= 15'd0;
      dur_r       <= 8'd0;
      per_cnt_r   <= 15'd0;
      cs_cnt_r    <= '0;
      dur_cnt_r   <= 8'd0;
      note_over_r <= 3'b000;
    end else begin
      note_over_r <= 3'b000;
      if (state_r == IDLE && state_s == PLAY) begin
        sel_r     <= sel_s;
        per_r     <= per_sel_s;
        dur_r     <= dur_sel_s;
        per_cnt_r <= 15'd0;
        cs_cnt_r  <= '0;
        dur_cnt_r <= 8'd0;
      end else if (state_r == PLAY && state_s == PLAY) begin
        if (per_r < 15'd2 || per_cnt_r >= (per_r - 15'd1)) begin
          per_cnt_r <= 15'd0;
        end else begin
          per_cnt_r <= per_cnt_r + 15'd1;
        end
        if (tick_s) begin
          cs_cnt_r  <= '0;
          dur_cnt_r <= dur_cnt_r + 8'd1;
        end else begin
          cs_cnt_r  <= cs_cnt_r + CS_W'(1);
        end
      end else begin
        // Completion without stop is the only path that reports note_over
        if (state_r == PLAY && !stop) begin
          note_over_r <= sel_r;
        end
        per_cnt_r <= 15'd0;
        cs_cnt_r  <= '0;
        dur_cnt_r <= 8'd0;
      end
    end
  end

  // Outputs decoded from registered state only
  always_comb begin
    tone_hi_s = (per_cnt_r < (per_r >> 1));
    gnt       = 3'b000;
    busy      = 1'b0;
    piezo     = 1'b0;
    piezo_n   = 1'b0;
    if (state_r == PLAY) begin
      gnt  = sel_r;
      busy = 1'b1;
      if (per_r >= 15'd2) begin
        piezo   = tone_hi_s;
        piezo_n = ~tone_hi_s;
      end else begin
        piezo   = 1'b0;
        piezo_n = 1'b0;
      end
    end else begin
      gnt  = 3'b000;
      busy = 1'b0;
    end
  end

  assign note_over = note_over_r;

endmodule

// File: tb/tb_piezo_arb.sv
// Bench for piezo_arb: vector table, directed corner sequences and random
// traffic compared every cycle against a cycle-count reference model.
module tb_piezo_arb;

  localparam int CS = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  req = 3'b000;
  logic        stop = 1'b0;
  logic [14:0] per_in [3];
  logic [7:0]  dur_in [3];
  logic [2:0]  gnt, note_over;
  logic        busy, piezo, piezo_n;

  int checks = 0;
  int failures = 0;

  // Reference model: whether a note plays, its owner, its parameters and cycles since grant
  int         m_play, m_own, m_per, m_dur, m_t;
  logic [2:0] m_over;

  typedef struct {
    logic [2:0] req;
    logic       stop;
    logic [2:0] gnt;
    logic [2:0] over;
    logic       busy;
    logic       pz;
    logic       pzn;
  } vec_t;

  vec_t tbl [10];

  piezo_arb #(.CS_CLKS(CS)) dut (
    .clk(clk), .rst_n(rst_n), .req(req),
    .note_per0(per_in[0]), .note_per1(per_in[1]), .note_per2(per_in[2]),
    .note_dur0(dur_in[0]), .note_dur1(dur_in[1]), .note_dur2(dur_in[2]),
    .stop(stop), .gnt(gnt), .note_over(note_over), .busy(busy),
    .piezo(piezo), .piezo_n(piezo_n)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [2:0] act, input logic [2:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_play = 0; m_own = 0; m_per = 0; m_dur = 0; m_t = 0; m_over = 3'b000;
  endtask

  task automatic model_edge();
    int lim;
    m_over = 3'b000;
    if (!rst_n) begin
      model_reset();
    end else if (stop) begin
      m_play = 0;
    end else if (m_play != 0) begin
      lim = (m_dur == 0) ? 1 : m_dur * CS;
      if (m_t == lim - 1) begin
        m_play = 0;
        m_over = 3'(1 << m_own);
      end else begin
        m_t++;
      end
    end else if (req != 3'b000) begin
      m_own  = req[0] ? 0 : (req[1] ? 1 : 2);
      m_per  = int'(per_in[m_own]);
      m_dur  = int'(dur_in[m_own]);
      m_t    = 0;
      m_play = 1;
    end
  endtask

  task automatic compare_model();
    logic [2:0] e_gnt;
    logic       tone, e_pz, e_pzn;
    e_gnt = (m_play != 0) ? 3'(1 << m_own) : 3'b000;
    tone  = (m_play != 0) && (m_per >= 2);
    e_pz  = tone && ((m_t % (m_per < 1 ? 1 : m_per)) < (m_per / 2));
    e_pzn = tone && !e_pz;
    chk("gnt", gnt, e_gnt);
    chk("note_over", note_over, m_over);
    chk("busy", {2'b00, busy}, {2'b00, (m_play != 0)});
    chk("piezo", {1'b0, piezo, piezo_n}, {1'b0, e_pz, e_pzn});
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_model();
  endtask

  task automatic drain();
    int n = 0;
    req = 3'b000;
    stop = 1'b0;
    while (busy === 1'b1 && n < 40) begin
      step();
      n++;
    end
    step();
    chk("drain_idle", {2'b00, busy}, 3'b000);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      per_in[i] = 15'd4;
      dur_in[i] = 8'd1;
    end
    model_reset();

    // Reset held with all requests active
    req = 3'b111;
    step();
    step();
    chk("rst_gnt", gnt, 3'b000);
    chk("rst_misc", {busy, piezo, piezo_n}, 3'b000);
    chk("rst_over", note_over, 3'b000);
    rst_n = 1'b1;
    step();
    chk("rst_release_gnt", gnt, 3'b001);
    drain();

    // Single note table: per=8, dur=2 gives 8 PLAY cycles, 4 high then 4 low
    per_in[1] = 15'd8;
    dur_in[1] = 8'd2;
    tbl[0] = '{3'b010, 1'b0, 3'b010, 3'b000, 1'b1, 1'b1, 1'b0};
    for (int i = 1; i < 8; i++)
      tbl[i] = '{3'b000, 1'b0, 3'b010, 3'b000, 1'b1, (i < 4), (i >= 4)};
    tbl[8] = '{3'b000, 1'b0, 3'b000, 3'b010, 1'b0, 1'b0, 1'b0};
    tbl[9] = '{3'b000, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 10; i++) begin
      req  = tbl[i].req;
      stop = tbl[i].stop;
      step();
      chk($sformatf("tbl%0d_gnt", i), gnt, tbl[i].gnt);
      chk($sformatf("tbl%0d_over", i), note_over, tbl[i].over);
      chk($sformatf("tbl%0d_out", i), {busy, piezo, piezo_n}, {tbl[i].busy, tbl[i].pz, tbl[i].pzn});
    end

    // Simultaneous requests: req[0] first with dur=0, then req[2]
    per_in[0] = 15'd4; dur_in[0] = 8'd0;
    per_in[2] = 15'd6; dur_in[2] = 8'd1;
    req = 3'b101;
    step();
    chk("sim_gnt0", gnt, 3'b001);
    step();
    chk("sim_over0", note_over, 3'b001);
    chk("sim_busy_over", {2'b00, busy}, 3'b000);
    req = 3'b100;
    step();
    chk("sim_gnt2", gnt, 3'b100);
    drain();

    // No preemption: req[2] with dur=3, req[0] raised mid-note
    per_in[2] = 15'd4; dur_in[2] = 8'd3;
    dur_in[0] = 8'd1;
    req = 3'b100;
    step();
    for (int i = 1; i < 12; i++) begin
      if (i == 3) req = 3'b101;
      step();
      chk("nopre_gnt", gnt, 3'b100);
    end
    step();
    chk("nopre_over", note_over, 3'b100);
    step();
    chk("nopre_next", gnt, 3'b001);
    drain();

    // Stop on the 5th PLAY cycle, then stop and req held together
    per_in[1] = 15'd6; dur_in[1] = 8'd3;
    req = 3'b010;
    step();
    for (int i = 0; i < 4; i++) step();
    stop = 1'b1;
    step();
    chk("stop_gnt", gnt, 3'b000);
    chk("stop_pz", {1'b0, piezo, piezo_n}, 3'b000);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stop_hold_gnt", gnt, 3'b000);
      chk("stop_no_over", note_over, 3'b000);
    end
    stop = 1'b0;
    drain();

    // Rest note: per=0, dur=3 is silent for 12 cycles and still completes
    per_in[1] = 15'd0; dur_in[1] = 8'd3;
    req = 3'b010;
    for (int i = 0; i < 12; i++) begin
      step();
      if (i == 0) req = 3'b000;
      chk("rest_pz", {busy, piezo, piezo_n}, 3'b100);
    end
    step();
    chk("rest_over", note_over, 3'b010);

    // Zero duration: one PLAY cycle then note_over
    per_in[2] = 15'd5; dur_in[2] = 8'd0;
    req = 3'b100;
    step();
    chk("dur0_gnt", gnt, 3'b100);
    req = 3'b000;
    step();
    chk("dur0_over", note_over, 3'b100);

    // Random traffic including rare stop and mid-note reset
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 3) == 0) req = 3'($urandom_range(0, 7));
      for (int i = 0; i < 3; i++) begin
        if ($urandom_range(0, 2) == 0) begin
          per_in[i] = 15'($urandom_range(0, 10));
          dur_in[i] = 8'($urandom_range(0, 3));
        end
      end
      stop = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 499) == 0) begin
        rst_n = 1'b0;
        model_reset();
        #1;
        compare_model();
      end else begin
        rst_n = 1'b1;
      end
      step();
    end
    rst_n = 1'b1;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
